// File: rtl/sha256_stream.sv
// rtl/sha256_stream.sv - streaming SHA-256 block hasher, ROUNDS_PER_CYCLE rounds per clock.
// Optional SHA-224 output mode is enabled with the SHA256_STREAM_SHA224_EN macro.
module sha256_stream #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] M_in,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] H_out,
`ifdef SHA256_STREAM_SHA224_EN
  input  logic         mode224,
`endif
  output logic         busy
);

  generate
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [5:0] LAST_STEP = 6'(64 - ROUNDS_PER_CYCLE);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        first_q, last_q;
  logic [31:0] h [8];
  logic [31:0] v [8];
  logic [31:0] w [16];
  logic [31:0] v_nxt [8];
  logic [31:0] w_nxt [16];
  logic [31:0] t1, t2, ws;
  logic [0:7][31:0] iv;
  logic [255:0] digest;
  logic        accept;

  assign accept = (state == IDLE) && in_valid;

`ifdef SHA256_STREAM_SHA224_EN
  localparam logic [0:7][31:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
  logic mode_q;
  assign iv = mode224 ? IV224 : IV256;
`else
  assign iv = IV256;
`endif

  // Unrolled compression rounds; W window slides one word per round.
  always_comb begin
    v_nxt = v;
    w_nxt = w;
    t1 = '0;
    t2 = '0;
    ws = '0;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      t1 = v_nxt[7] + bsig1(v_nxt[4]) + ((v_nxt[4] & v_nxt[5]) ^ (~v_nxt[4] & v_nxt[6]))
         + K[cnt + 6'(r)] + w_nxt[0];
      t2 = bsig0(v_nxt[0]) + ((v_nxt[0] & v_nxt[1]) ^ (v_nxt[0] & v_nxt[2]) ^ (v_nxt[1] & v_nxt[2]));
      for (int i = 7; i > 0; i--) v_nxt[i] = v_nxt[i-1];
      v_nxt[4] = v_nxt[4] + t1;
      v_nxt[0] = t1 + t2;
      ws = ssig1(w_nxt[14]) + w_nxt[9] + ssig0(w_nxt[1]) + w_nxt[0];
      for (int i = 0; i < 15; i++) w_nxt[i] = w_nxt[i+1];
      w_nxt[15] = ws;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ROUND;
      ROUND:   if (cnt == LAST_STEP) state_nxt = ADD;
      ADD:     state_nxt = last_q ? DONE : IDLE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h[i] <= '0;
        v[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
`ifdef SHA256_STREAM_SHA224_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt    <= '0;
          last_q <= in_last;
          for (int i = 0; i < 16; i++) w[i] <= M_in[511-32*i -: 32];
          for (int i = 0; i < 8; i++) begin
            v[i] <= first_q ? iv[i] : h[i];
            if (first_q) h[i] <= iv[i];
          end
          first_q <= 1'b0;
`ifdef SHA256_STREAM_SHA224_EN
          if (first_q) mode_q <= mode224;
`endif
        end
        ROUND: begin
          cnt <= cnt + 6'(ROUNDS_PER_CYCLE);
          v   <= v_nxt;
          w   <= w_nxt;
        end
        ADD: for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
        DONE: if (out_ready) first_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) digest[255-32*i -: 32] = h[i];
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    H_out     = out_valid ? digest : '0;
`ifdef SHA256_STREAM_SHA224_EN
    if (mode_q) H_out[31:0] = '0;
`endif
  end

endmodule

// File: tb/tb_sha256_stream.sv
// tb/tb_sha256_stream.sv - directed-vector bench for sha256_stream at 1 and 4 rounds per cycle.
module tb_sha256_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic         mode224 = 1'b0;
  logic         sel = 1'b0;
  logic [511:0] m_in = '0;

  logic         in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4;
  logic [255:0] h_out1, h_out4;
  logic         in_ready, out_valid, busy;
  logic [255:0] h_out;

  int n_checks = 0;
  int n_pass = 0;

  localparam logic [511:0] BLK_ABC  = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_2A   = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B   = {448'h0, 64'h1c0};
  localparam logic [255:0] DIG_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2BLK = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  always #5 clk = ~clk;

  sha256_stream #(.ROUNDS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready1),
    .M_in(m_in), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready & ~sel),
    .H_out(h_out1),
`ifdef SHA256_STREAM_SHA224_EN
    .mode224(mode224),
`endif
    .busy(busy1));

  sha256_stream #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready4),
    .M_in(m_in), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready & sel),
    .H_out(h_out4),
`ifdef SHA256_STREAM_SHA224_EN
    .mode224(mode224),
`endif
    .busy(busy4));

  assign in_ready  = sel ? in_ready4  : in_ready1;
  assign out_valid = sel ? out_valid4 : out_valid1;
  assign busy      = sel ? busy4      : busy1;
  assign h_out     = sel ? h_out4     : h_out1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic accept(input logic [511:0] blk, input logic last);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    m_in     = blk;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic last, input int exp_lat, input string tag);
    int lat = 0;
    while (!(last ? out_valid : in_ready) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check(tag, 256'(lat), 256'(exp_lat));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 256'(out_valid), 256'(0));
    check({tag, "_h_zero"}, h_out, 256'(0));
    check({tag, "_rdy"}, 256'(in_ready), 256'(1));
  endtask

  task automatic run_msg(input int lat, input string tag);
    accept(BLK_ABC, 1'b1);
    wait_done(1'b1, lat, {tag, "_lat"});
    check({tag, "_dig"}, h_out, DIG_ABC);
    consume(tag);
  endtask

  task automatic run_two(input int lat, input string tag);
    accept(BLK_2A, 1'b0);
    wait_done(1'b0, lat, {tag, "_b1_lat"});
    check({tag, "_b1_noout"}, 256'(out_valid), 256'(0));
    accept(BLK_2B, 1'b1);
    wait_done(1'b1, lat, {tag, "_b2_lat"});
    check({tag, "_dig"}, h_out, DIG_2BLK);
    consume(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ov", 256'(out_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_h", h_out, 256'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    check("idle_rdy", 256'(in_ready), 256'(1));
    check("idle_ov", 256'(out_valid), 256'(0));

    run_msg(65, "abc_r1");
    run_two(65, "two_r1");

    // Stall the consumer with a competing block offered; nothing may move.
    accept(BLK_ABC, 1'b1);
    wait_done(1'b1, 65, "stall_lat");
    in_valid = 1'b1;
    m_in     = BLK_2A;
    in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_h", h_out, DIG_ABC);
      check("stall_flags", 256'({in_ready, out_valid}), 256'(2'b01));
    end
    in_valid = 1'b0;
    consume("stall");
    run_msg(65, "after_stall");

    accept(BLK_2A, 1'b0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ov", 256'(out_valid), 256'(0));
    check("midrst_h", h_out, 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_msg(65, "post_rst");

    sel = 1'b1;
    run_msg(17, "abc_r4");
    run_two(17, "two_r4");
    sel = 1'b0;

`ifdef SHA256_STREAM_SHA224_EN
    mode224 = 1'b1;
    accept(BLK_ABC, 1'b1);
    mode224 = 1'b0;
    wait_done(1'b1, 65, "sha224_lat");
    check("sha224_dig", h_out,
          {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0});
    consume("sha224");
    run_msg(65, "after_224");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
